alu_mdu: RTL

Parametrised, handshaked execution unit for the NeuroRISC core. It combines the integer ALU operations with the RV32M multiply/divide operations.
- Base ALU ops finish in one cycle, with a registered result.
- Multiply/divide ops run iteratively, one bit per cycle (radix-2).
- Sits in the execute stage between the decode/operand-fetch stage (upstream) and writeback (downstream).
- Valid/ready on both sides lets the pipeline stall while a long op is in flight.

---
 rtl/alu_mdu.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/alu_mdu.sv
`timescale 1ns/1ps
// alu_mdu: integer ALU plus RV32M multiply/divide execution unit.
//
// Base ALU ops finish in one cycle with a registered result. M-extension ops
// run a radix-2 shift/add (multiply) or restoring (divide) iteration, one bit
// per cycle. A signed M op is converted to magnitudes when it is accepted, and
// the sign is fixed up in the last iteration cycle.
//
// Ports:
//   clk, rst_n             clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready    request handshake
//   in_a, in_b             operands (rs1, rs2/imm)
//   func                   funct3 encoding
//   sub_sra                funct7[5]: SUB/SRA select, ignored for M ops
//   muldiv                 1 = M-extension op
//   kill                   synchronous abort of the in-flight op
//   out_valid / out_ready  result handshake
//   out_Q                  result
//   EQ, A_lt_B, A_lt_UB    operand compare flags, held with out_Q
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. in_ready is high in IDLE, or in DONE when the current result is
// being taken in the same cycle, and it is low whenever kill is high.
// out_valid stays high, with out_Q and the flags stable, until out_ready.
module alu_mdu #(
  parameter int WIDTH = 32,
  localparam int SHW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       func,
  input  logic             sub_sra,
  input  logic             muldiv,
  input  logic             kill,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_Q,
  output logic             EQ,
  output logic             A_lt_B,
  output logic             A_lt_UB
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t           state;
  logic [2:0]       op_func;   // captured funct3; bit 2 selects divide
  logic [WIDTH-1:0] a_r;       // raw dividend, used as the divide-by-zero remainder
  logic             b_zero;    // divisor was zero
  logic             neg_p;     // product / quotient must be negated
  logic             neg_r;     // remainder must be negated
  logic             eq_r, lt_r, ltu_r;
  logic [WIDTH-1:0] dvs;       // multiplicand or divisor magnitude
  logic [WIDTH-1:0] acc;       // product high half or partial remainder
  logic [WIDTH-1:0] lo;        // multiplier/product low half or dividend/quotient
  logic [SHW-1:0]   cnt;

  logic accept;
  assign in_ready = !kill && (state == S_IDLE || (state == S_DONE && out_ready));
  assign accept   = in_valid && in_ready;

  // Compare flags and base ALU result from the live operands.
  logic             eq_c, lt_c, ltu_c;
  logic [WIDTH-1:0] alu_res;
  assign eq_c  = (in_a == in_b);
  assign lt_c  = ($signed(in_a) < $signed(in_b));
  assign ltu_c = (in_a < in_b);

  always_comb begin
    alu_res = '0;
    case (func)
      3'b000: alu_res = sub_sra ? (in_a - in_b) : (in_a + in_b);
      3'b001: alu_res = in_a << in_b[SHW-1:0];
      3'b010: alu_res = {{(WIDTH-1){1'b0}}, lt_c};
      3'b011: alu_res = {{(WIDTH-1){1'b0}}, ltu_c};
      3'b100: alu_res = in_a ^ in_b;
      3'b101: alu_res = sub_sra ? $unsigned($signed(in_a) >>> in_b[SHW-1:0])
                                : (in_a >> in_b[SHW-1:0]);
      3'b110: alu_res = in_a | in_b;
      default: alu_res = in_a & in_b;
    endcase
  end

  // Operand signedness: MULH, MULHSU, DIV, REM treat A as signed;
  // MULH, DIV, REM treat B as signed. MUL low bits do not depend on sign.
  logic             a_sgn, b_sgn, neg_a, neg_b;
  logic [WIDTH-1:0] mag_a, mag_b;
  assign a_sgn = (func == 3'b001) || (func == 3'b010) || (func == 3'b100) || (func == 3'b110);
  assign b_sgn = (func == 3'b001) || (func == 3'b100) || (func == 3'b110);
  assign neg_a = a_sgn && in_a[WIDTH-1];
  assign neg_b = b_sgn && in_b[WIDTH-1];
  assign mag_a = neg_a ? (-in_a) : in_a;
  assign mag_b = neg_b ? (-in_b) : in_b;

  // One iteration step.
  logic [WIDTH:0]   sum;   // multiply: high half plus optional multiplicand
  logic [WIDTH:0]   sh;    // divide: partial remainder shifted left by one
  logic             ge;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] acc_n, lo_n;
  assign sum  = {1'b0, acc} + (lo[0] ? {1'b0, dvs} : '0);
  assign sh   = {acc, lo[WIDTH-1]};
  assign ge   = (sh >= {1'b0, dvs});
  // When ge holds the true difference is below dvs, so it fits in WIDTH bits.
  assign diff = sh[WIDTH-1:0] - dvs;

  always_comb begin
    acc_n = '0;
    lo_n  = '0;
    if (op_func[2]) begin
      acc_n = ge ? diff : sh[WIDTH-1:0];
      lo_n  = {lo[WIDTH-2:0], ge};
    end else begin
      acc_n = sum[WIDTH:1];
      lo_n  = {sum[0], lo[WIDTH-1:1]};
    end
  end

  // Final result with sign fix-up, taken from the last iteration's values.
  logic [2*WIDTH-1:0] prod, prod_s;
  logic [WIDTH-1:0]   md_res;
  assign prod   = {acc_n, lo_n};
  assign prod_s = neg_p ? (-prod) : prod;

  always_comb begin
    md_res = '0;
    if (op_func[2]) begin
      if (op_func[1])
        md_res = b_zero ? a_r : (neg_r ? (-acc_n) : acc_n);
      else
        md_res = b_zero ? '1 : (neg_p ? (-lo_n) : lo_n);
    end else begin
      md_res = (op_func[1:0] == 2'b00) ? prod_s[WIDTH-1:0] : prod_s[2*WIDTH-1:WIDTH];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      out_valid <= 1'b0;
      out_Q     <= '0;
      EQ        <= 1'b0;
      A_lt_B    <= 1'b0;
      A_lt_UB   <= 1'b0;
      op_func   <= '0;
      a_r       <= '0;
      b_zero    <= 1'b0;
      neg_p     <= 1'b0;
      neg_r     <= 1'b0;
      eq_r      <= 1'b0;
      lt_r      <= 1'b0;
      ltu_r     <= 1'b0;
      dvs       <= '0;
      acc       <= '0;
      lo        <= '0;
      cnt       <= '0;
    end else if (kill && state != S_IDLE) begin
      state     <= S_IDLE;
      out_valid <= 1'b0;
    end else if (accept) begin
      op_func <= func;
      a_r     <= in_a;
      b_zero  <= (in_b == '0);
      neg_p   <= neg_a ^ neg_b;
      neg_r   <= neg_a;
      eq_r    <= eq_c;
      lt_r    <= lt_c;
      ltu_r   <= ltu_c;
      cnt     <= '0;
      acc     <= '0;
      if (muldiv) begin
        state     <= S_BUSY;
        out_valid <= 1'b0;
        dvs       <= func[2] ? mag_b : mag_a;
        lo        <= func[2] ? mag_a : mag_b;
      end else begin
        state     <= S_DONE;
        out_valid <= 1'b1;
        out_Q     <= alu_res;
        EQ        <= eq_c;
        A_lt_B    <= lt_c;
        A_lt_UB   <= ltu_c;
      end
    end else begin
      case (state)
        S_BUSY: begin
          acc <= acc_n;
          lo  <= lo_n;
          cnt <= cnt + 1'b1;
          if (cnt == SHW'(WIDTH - 1)) begin
            state     <= S_DONE;
            out_valid <= 1'b1;
            out_Q     <= md_res;
            EQ        <= eq_r;
            A_lt_B    <= lt_r;
            A_lt_UB   <= ltu_r;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
